// File: rtl/reg_file_sb_pkg.sv
// Shared parameters for the tagged register-file scoreboard.
// Holds the data width, the default port and tag sizing, and the r0 policy.
package reg_file_sb_pkg;
  localparam int WORD        = 32;
  localparam int TW_DEF      = 4;
  localparam int NRD_DEF     = 2;
  localparam int NWB_DEF     = 2;
  localparam int R0_ZERO_DEF = 1;
endpackage

// File: rtl/reg_file_sb_entry.sv
// One register-file entry: data word, busy flag and reservation tag.
// Writeback strobes arrive already tag-matched. Flush outranks writeback and reserve.
module reg_file_entry
  import reg_file_sb_pkg::*;
#(
  parameter int TW = TW_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_rsv,
  input  logic [TW-1:0]   i_rsv_tag,
  input  logic            i_wb,
  input  logic [WORD-1:0] i_wb_data,
  input  logic            i_flush,
  output logic [WORD-1:0] o_data,
  output logic            o_busy,
  output logic [TW-1:0]   o_tag
);
  logic [WORD-1:0] r_data;
  logic            r_busy;
  logic [TW-1:0]   r_tag;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data <= '0;
      r_busy <= 1'b0;
      r_tag  <= '0;
    end else if (i_flush) begin
      r_busy <= 1'b0;
    end else begin
      if (i_wb) begin
        r_data <= i_wb_data;
        r_busy <= 1'b0;
      end
      // A same-cycle reserve lands after the writeback, so the entry stays busy under the new tag.
      if (i_rsv) begin
        r_busy <= 1'b1;
        r_tag  <= i_rsv_tag;
      end
    end
  end

  assign o_data = r_data;
  assign o_busy = r_busy;
  assign o_tag  = r_tag;
endmodule

// File: rtl/reg_file_sb.sv
// Register file with a tagged write-reservation scoreboard.
// Decodes reserves, tag-matches and prioritises writebacks, and muxes reads with optional bypass.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int NREG    = 32,
  parameter int AW      = 5,
  parameter int TW      = TW_DEF,
  parameter int NRD     = NRD_DEF,
  parameter int NWB     = NWB_DEF,
  parameter int R0_ZERO = R0_ZERO_DEF,
  parameter int BYPASS  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*WORD-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  output logic [NRD*TW-1:0]   rd_tag_o,
  input  logic                rsv_i,
  input  logic [AW-1:0]       rsv_addr_i,
  input  logic [TW-1:0]       rsv_tag_i,
  input  logic [NWB-1:0]      wb_i,
  input  logic [NWB*AW-1:0]   wb_addr_i,
  input  logic [NWB*TW-1:0]   wb_tag_i,
  input  logic [NWB*WORD-1:0] wb_data_i,
  input  logic                flush_i,
  output logic [NREG-1:0]     busy_o
);
  logic [WORD-1:0] w_data [NREG];
  logic [NREG-1:0] w_busy;
  logic [TW-1:0]   w_tag  [NREG];
  logic [NREG-1:0] w_rsv;
  logic [NREG-1:0] w_hit;
  logic [WORD-1:0] w_wbd  [NREG];
  logic [AW-1:0]   w_ra   [NRD];

  // Scan ports high to low so the lowest-index matching port ends up selected.
  always_comb begin
    w_rsv = '0;
    w_hit = '0;
    for (int a = 0; a < NREG; a++) begin
      w_wbd[a] = '0;
      w_rsv[a] = rsv_i && (rsv_addr_i == AW'(a));
      for (int p = NWB - 1; p >= 0; p--) begin
        if (wb_i[p] && (wb_addr_i[p*AW +: AW] == AW'(a)) && w_busy[a] &&
            (w_tag[a] == wb_tag_i[p*TW +: TW])) begin
          w_hit[a] = 1'b1;
          w_wbd[a] = wb_data_i[p*WORD +: WORD];
        end
      end
    end
    if (R0_ZERO != 0) begin
      w_rsv[0] = 1'b0;
      w_hit[0] = 1'b0;
    end
  end

  for (genvar a = 0; a < NREG; a++) begin : g_entry
    reg_file_entry #(.TW(TW)) u_entry (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_rsv     (w_rsv[a]),
      .i_rsv_tag (rsv_tag_i),
      .i_wb      (w_hit[a]),
      .i_wb_data (w_wbd[a]),
      .i_flush   (flush_i),
      .o_data    (w_data[a]),
      .o_busy    (w_busy[a]),
      .o_tag     (w_tag[a])
    );
  end

  assign busy_o = w_busy;

  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    rd_tag_o  = '0;
    for (int k = 0; k < NRD; k++) begin
      w_ra[k] = rd_addr_i[k*AW +: AW];
      if ((int'(w_ra[k]) < NREG) && !((R0_ZERO != 0) && (w_ra[k] == '0))) begin
        rd_data_o[k*WORD +: WORD] = w_data[w_ra[k]];
        rd_busy_o[k]              = w_busy[w_ra[k]];
        rd_tag_o[k*TW +: TW]      = w_tag[w_ra[k]];
        // A flush kills the writeback, so it must not be forwarded either.
        if ((BYPASS != 0) && !flush_i && w_hit[w_ra[k]]) begin
          rd_data_o[k*WORD +: WORD] = w_wbd[w_ra[k]];
          rd_busy_o[k]              = 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: reference scoreboard model checked every cycle,
// directed scenarios with literal expectations, then a burst of mixed traffic.
module tb_reg_file_sb;
  import reg_file_sb_pkg::*;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int TW   = 4;
  localparam int NRD  = 2;
  localparam int NWB  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   rd_addr_i;
  logic [NRD*WORD-1:0] rd_data_o;
  logic [NRD-1:0]      rd_busy_o;
  logic [NRD*TW-1:0]   rd_tag_o;
  logic                rsv_i;
  logic [AW-1:0]       rsv_addr_i;
  logic [TW-1:0]       rsv_tag_i;
  logic [NWB-1:0]      wb_i;
  logic [NWB*AW-1:0]   wb_addr_i;
  logic [NWB*TW-1:0]   wb_tag_i;
  logic [NWB*WORD-1:0] wb_data_i;
  logic                flush_i;
  logic [NREG-1:0]     busy_o;

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  logic [WORD-1:0] m_data [NREG];
  logic            m_busy [NREG];
  logic [TW-1:0]   m_tag  [NREG];

  reg_file_sb #(.NREG(NREG), .AW(AW), .TW(TW), .NRD(NRD), .NWB(NWB),
                .R0_ZERO(1), .BYPASS(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr_i  (rd_addr_i),
    .rd_data_o  (rd_data_o),
    .rd_busy_o  (rd_busy_o),
    .rd_tag_o   (rd_tag_o),
    .rsv_i      (rsv_i),
    .rsv_addr_i (rsv_addr_i),
    .rsv_tag_i  (rsv_tag_i),
    .wb_i       (wb_i),
    .wb_addr_i  (wb_addr_i),
    .wb_tag_i   (wb_tag_i),
    .wb_data_i  (wb_data_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
  endtask

  // Lowest writeback port that hits a live reservation on address a, or -1.
  function automatic int wb_match_port(input int a);
    if (a == 0) return -1;
    for (int p = 0; p < NWB; p++)
      if (wb_i[p] && (int'(wb_addr_i[p*AW +: AW]) == a) && m_busy[a] &&
          (m_tag[a] == wb_tag_i[p*TW +: TW]))
        return p;
    return -1;
  endfunction

  // ---------------- reference model ----------------
  always @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < NREG; a++) begin
        m_data[a] <= '0;
        m_busy[a] <= 1'b0;
        m_tag[a]  <= '0;
      end
      chk_en <= 1'b1;
    end else if (flush_i) begin
      for (int a = 0; a < NREG; a++) m_busy[a] <= 1'b0;
    end else begin
      for (int a = 1; a < NREG; a++) begin
        int p;
        p = wb_match_port(a);
        if (p >= 0) begin
          m_data[a] <= wb_data_i[p*WORD +: WORD];
          m_busy[a] <= 1'b0;
        end
      end
      if (rsv_i && rsv_addr_i != '0) begin
        m_busy[rsv_addr_i] <= 1'b1;
        m_tag[rsv_addr_i]  <= rsv_tag_i;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      logic [NREG-1:0] exp_busy;
      for (int a = 0; a < NREG; a++) exp_busy[a] = m_busy[a];
      check("busy_o", 64'(busy_o), 64'(exp_busy));
      for (int k = 0; k < NRD; k++) begin
        int a, p;
        logic [WORD-1:0] ed;
        logic            eb;
        logic [TW-1:0]   et;
        a = int'(rd_addr_i[k*AW +: AW]);
        ed = '0; eb = 1'b0; et = '0;
        if (a != 0) begin
          ed = m_data[a]; eb = m_busy[a]; et = m_tag[a];
          p = wb_match_port(a);
          if (!flush_i && p >= 0) begin
            ed = wb_data_i[p*WORD +: WORD];
            eb = 1'b0;
          end
        end
        check($sformatf("rd_port%0d{data,busy,tag}", k),
              64'({rd_data_o[k*WORD +: WORD], rd_busy_o[k], rd_tag_o[k*TW +: TW]}),
              64'({ed, eb, et}));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    rsv_i = 1'b0; rsv_addr_i = '0; rsv_tag_i = '0;
    wb_i = '0; wb_addr_i = '0; wb_tag_i = '0; wb_data_i = '0;
    flush_i = 1'b0; rd_addr_i = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic reserve(input int a, input int t);
    rsv_i = 1'b1; rsv_addr_i = AW'(a); rsv_tag_i = TW'(t);
  endtask

  task automatic wb(input int p, input int a, input int t, input logic [WORD-1:0] d);
    wb_i[p] = 1'b1;
    wb_addr_i[p*AW +: AW]   = AW'(a);
    wb_tag_i[p*TW +: TW]    = TW'(t);
    wb_data_i[p*WORD +: WORD] = d;
  endtask

  task automatic rd(input int k, input int a);
    rd_addr_i[k*AW +: AW] = AW'(a);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    idle();
    step(); step();
    rst = 1'b0;

    // Reset in the middle of traffic, with a reserve pending.
    reserve(4, 1); step();
    idle(); rst = 1'b1; reserve(6, 2); step();
    rst = 1'b0; idle(); rd(0, 4); rd(1, 6); #1;
    check("lit_reset_busy_o", 64'(busy_o), 64'h0);
    check("lit_reset_rd_data", 64'(rd_data_o), 64'h0);
    check("lit_reset_rd_busy", 64'(rd_busy_o), 64'h0);

    // Basic reserve then writeback.
    reserve(5, 3); step();
    idle(); rd(0, 5); #1;
    check("lit_r5_busy", 64'(rd_busy_o[0]), 64'h1);
    check("lit_r5_tag", 64'(rd_tag_o[TW-1:0]), 64'h3);
    wb(0, 5, 3, 32'hDEADBEEF); step();
    idle(); rd(0, 5); #1;
    check("lit_r5_busy_o", 64'(busy_o[5]), 64'h0);
    check("lit_r5_data", 64'(rd_data_o[WORD-1:0]), 64'hDEADBEEF);

    // Stale writeback is dropped after a re-reserve.
    reserve(7, 1); step();
    idle(); reserve(7, 2); step();
    idle(); wb(0, 7, 1, 32'h11); rd(0, 7); step();
    idle(); rd(0, 7); #1;
    check("lit_r7_stale_busy", 64'(rd_busy_o[0]), 64'h1);
    check("lit_r7_stale_data", 64'(rd_data_o[WORD-1:0]), 64'h0);
    wb(1, 7, 2, 32'h22); step();
    idle(); rd(0, 7); #1;
    check("lit_r7_data", 64'(rd_data_o[WORD-1:0]), 64'h22);
    check("lit_r7_busy", 64'(rd_busy_o[0]), 64'h0);

    // Same-cycle writeback and re-reserve.
    reserve(9, 4); step();
    idle(); wb(0, 9, 4, 32'hAA); reserve(9, 5); step();
    idle(); rd(1, 9); #1;
    check("lit_r9_state", 64'({rd_data_o[WORD +: WORD], rd_busy_o[1], rd_tag_o[TW +: TW]}),
          64'({32'hAA, 1'b1, 4'h5}));

    // Bypass on read port 1, then r0 stays hardwired.
    reserve(3, 6); step();
    idle(); wb(1, 3, 6, 32'h1234); rd(1, 3); #1;
    check("lit_bypass_data", 64'(rd_data_o[WORD +: WORD]), 64'h1234);
    check("lit_bypass_busy", 64'(rd_busy_o[1]), 64'h0);
    step();
    idle(); reserve(0, 7); wb(0, 0, 0, 32'h99); step();
    idle(); rd(0, 0); #1;
    check("lit_r0_read", 64'({rd_data_o[WORD-1:0], rd_busy_o[0], rd_tag_o[TW-1:0]}), 64'h0);
    check("lit_r0_busy_o", 64'(busy_o[0]), 64'h0);

    // Two ports hitting one entry: port 0 wins.
    reserve(10, 1); step();
    idle(); wb(0, 10, 1, 32'hA0); wb(1, 10, 1, 32'hB0); step();
    idle(); rd(0, 10); #1;
    check("lit_prio_data", 64'(rd_data_o[WORD-1:0]), 64'hA0);

    // Flush discards reservations and a concurrent matching writeback.
    reserve(1, 1); step();
    idle(); reserve(2, 2); step();
    idle(); reserve(3, 3); step();
    idle(); flush_i = 1'b1; wb(0, 2, 2, 32'h55); rd(0, 2); #1;
    check("lit_flush_nobypass", 64'({rd_data_o[WORD-1:0], rd_busy_o[0]}), 64'({32'h0, 1'b1}));
    step();
    idle(); rd(0, 2); #1;
    check("lit_flush_busy_o", 64'(busy_o), 64'h0);
    check("lit_flush_r2", 64'({rd_data_o[WORD-1:0], rd_tag_o[TW-1:0]}), 64'({32'h0, 4'h2}));

    // Mixed traffic; about half the writebacks carry the live tag.
    for (int i = 0; i < 80; i++) begin
      idle();
      if ($urandom_range(0, 1) == 1) reserve($urandom_range(0, 15), $urandom_range(0, 15));
      for (int p = 0; p < NWB; p++) begin
        if ($urandom_range(0, 1) == 1) begin
          int a;
          a = $urandom_range(0, 15);
          wb(p, a, ($urandom_range(0, 1) == 1) ? int'(m_tag[a]) : $urandom_range(0, 15), $urandom);
        end
      end
      flush_i = ($urandom_range(0, 15) == 0);
      rd(0, $urandom_range(0, 15));
      rd(1, $urandom_range(0, 15));
      step();
    end

    idle(); step(); step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
